br_local_inject_arbiter: RTL and testbench
==========================================

// Module: br_local_inject_arbiter
// PURPOSE
//  Shares the single BrLite local injection port between N_REQ on-tile requesters
//  (kernel, TaskInjector, monitors) with registered round-robin arbitration.
//  Sits between the requesters and the router's local rx/ack/data_i handshake.
//  Latches the winner's br_data_t and holds it until ack.
//  Keeps per-requester saturating wait counters for the traffic debugger.
// PARAMETERS
//  N_REQ      3   number of requesters (2..8)
//  WAIT_W     16  width of each per-requester wait counter
//  IDX_W      $clog2(N_REQ)  derived; width of grant index
// PORTS
//  clk_i          in   1                  clock
//  rst_ni         in   1                  async active-low reset
//  req_i          in   N_REQ              per-requester broadcast request, level
//  req_data_i     in   N_REQ x br_data_t  per-requester payload, stable while req high
//  req_ack_o      out  N_REQ              one-cycle ack to the granted requester
//  tx_o           out  1                  request to BrLite local port (router rx_i)
//  data_o         out  br_data_t          latched payload to BrLite
//  ack_i          in   1                  BrLite acceptance pulse (router ack_rx_i)
//  busy_o         out  1                  grant outstanding
//  grant_idx_o    out  IDX_W              index of current/last winner
//  wait_cnt_o     out  N_REQ x WAIT_W     cycles each requester has waited
// BEHAVIOUR
//  Reset: tx_o=0, data_o='0, req_ack_o='0, busy_o=0, grant_idx_o=0, rr_ptr=0,
//   wait_cnt_o all 0, FSM=IDLE. Reset asserted mid-grant aborts the transfer;
//   no ack is delivered to the requester.
//  FSM states and transitions:
//   IDLE: if any req_i, pick first asserted index scanning rr_ptr, rr_ptr+1, ...
//     (mod N_REQ). At the clock edge: data_o<=req_data_i[w], grant_idx_o<=w,
//     tx_o<=1, busy_o<=1, go GRANT. Latency is 1 cycle from req_i high to tx_o high.
//   GRANT: hold tx_o and data_o unchanged until ack_i=1.
//     req_ack_o[grant_idx_o]=ack_i, combinational, same cycle as ack_i.
//     On the ack edge: tx_o<=0, busy_o<=0, rr_ptr<=(grant_idx_o+1) mod N_REQ,
//     go HOLDOFF.
//   HOLDOFF: one idle cycle so the acked requester can drop or refresh req_i.
//     Always returns to IDLE. No grant is issued in this cycle.
//  Minimum spacing is 3 cycles per transfer: grant, ack, holdoff.
//  A requester dropping req_i during GRANT does not cancel the transfer.
//   tx_o stays high until ack_i; the latched data is sent.
//  ack_i while not in GRANT is ignored: req_ack_o stays 0 and state is unchanged.
//  req_ack_o is one-hot or zero; never more than one bit set.
//  Wait counters: each cycle, wait_cnt[i]++ if req_i[i] && !(GRANT && grant_idx_o==i).
//   Increment saturates at 2^WAIT_W-1 with no wrap.
//   wait_cnt[i] clears to 0 on the cycle req_ack_o[i]=1.
//   If clear and increment happen in the same cycle, clear wins.
//   A requester that drops req without an ack keeps its count.
//  rr_ptr advances only on ack, so the winner becomes lowest priority next round.
//   A single persistent requester is re-granted after HOLDOFF.
// TESTING
//  Single req_i[1] at t0 -> tx_o=1 at t0+1, data_o=req_data_i[1]; ack_i at t0+3
//   -> req_ack_o=3'b010 same cycle, tx_o=0 next cycle, next grant no earlier than t0+5.
//  req_i=3'b111 held, ack 2 cycles after each tx_o -> grant order 0,1,2,0,
//   with the acked requester's wait_cnt cleared on each ack.
//  ack_i pulsed in IDLE with req_i=0 -> no req_ack_o, busy_o=0, rr_ptr unchanged.
//  Grant req 2, drop req_i[2] before ack -> tx_o held, data_o unchanged,
//   ack still routed to req_ack_o[2].
//  rst_ni low during GRANT -> tx_o=0, data_o='0, rr_ptr=0 immediately;
//   req held through reset -> regranted 1 cycle after release.
//  WAIT_W=4, req 0 held while req 1 is granted and ack withheld 20 cycles
//   -> wait_cnt[0] stops at 15.

Source files
------------

// File: rtl/br_local_inject_arbiter.sv
// Purpose : shares the single BrLite local injection port between N_REQ on-tile requesters
//           using registered round-robin arbitration, with per-requester saturating wait counters.
// Latency : 1 cycle from req_i high (arbiter idle) to tx_o high. Each transfer takes at least 3 cycles
//           (grant, ack, holdoff).
// Backpressure: the winner's payload is latched and tx_o is held until the router returns ack_i.
//           Other requesters wait; requesters are not stalled combinationally.
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   req_i[N]           per-requester level request
//   req_data_i[N*DW]   per-requester payload (br_data_t flattened, requester i at [i*DW +: DW])
//   req_ack_o[N]       one-cycle ack to the granted requester (same cycle as ack_i)
//   tx_o / data_o      request and latched payload toward the router's local rx
//   ack_i              router acceptance pulse
//   busy_o             grant outstanding
//   grant_idx_o        index of current/last winner
//   wait_cnt_o[N*WW]   per-requester saturating wait counters (requester i at [i*WW +: WW])
`timescale 1ns/1ps
module br_local_inject_arbiter #(
    parameter int N_REQ  = 3,
    parameter int WAIT_W = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ack_o,
    output logic                    tx_o,
    output logic [DATA_W-1:0]       data_o,
    input  logic                    ack_i,
    output logic                    busy_o,
    output logic [IDX_W-1:0]        grant_idx_o,
    output logic [N_REQ*WAIT_W-1:0] wait_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(N_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_rr_ptr_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  w_data_nxt;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_grant_idx_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt     [N_REQ];
    logic [WAIT_W-1:0]  w_wait_cnt_nxt [N_REQ];

    logic [DATA_W-1:0]  w_req_data [N_REQ];
    logic [N_REQ-1:0]   w_req_rot;
    logic [IDX_W:0]     w_pick_ofs;
    logic [IDX_W:0]     w_pick_sum;
    logic               w_pick_vld;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W:0]     w_ptr_inc;
    logic [IDX_W-1:0]   w_ptr_wrap;
    logic               w_ack_fire;

    // Unpack the flat payload bus into one entry per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_req_data[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: rotate requests so bit 0 is the rr_ptr requester, take the lowest
    // set bit, then map the offset back to an absolute index modulo N_REQ.
    always_comb begin
        w_req_rot  = N_REQ'({req_i, req_i} >> r_rr_ptr);
        w_pick_vld = |req_i;
        w_pick_ofs = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick_ofs = (IDX_W+1)'(k);
            end
        end
        w_pick_sum = {1'b0, r_rr_ptr} + w_pick_ofs;
        w_pick_idx = IDX_W'((w_pick_sum >= NREQ_W) ? (w_pick_sum - NREQ_W) : w_pick_sum);
    end

    // Pointer moves past the acked winner so it becomes lowest priority next round.
    always_comb begin
        w_ptr_inc  = {1'b0, r_grant_idx} + (IDX_W+1)'(1);
        w_ptr_wrap = IDX_W'((w_ptr_inc == NREQ_W) ? '0 : w_ptr_inc);
    end

    // ack_i is only meaningful while a grant is outstanding; elsewhere it is ignored.
    assign w_ack_fire = (r_state == ST_GRANT) && ack_i;

    always_comb begin
        req_ack_o = '0;
        if (w_ack_fire) begin
            req_ack_o = N_REQ'(1) << r_grant_idx;
        end
    end

    // Next-state / datapath process.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_tx_nxt        = r_tx;
        w_busy_nxt      = r_busy;
        w_data_nxt      = r_data;
        w_grant_idx_nxt = r_grant_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_data_nxt      = w_req_data[w_pick_idx];
                    w_grant_idx_nxt = w_pick_idx;
                    w_tx_nxt        = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Payload stays latched even if the requester drops req_i meanwhile.
                if (ack_i) begin
                    w_tx_nxt     = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_rr_ptr_nxt = w_ptr_wrap;
                    w_state_nxt  = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                // Gives the acked requester one cycle to drop or refresh its request.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Wait counters: count cycles spent requesting without being served; clear wins over increment.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_wait_cnt_nxt[i] = r_wait_cnt[i];
            if (req_ack_o[i]) begin
                w_wait_cnt_nxt[i] = '0;
            end else if (req_i[i] && !((r_state == ST_GRANT) && (r_grant_idx == IDX_W'(i)))) begin
                if (r_wait_cnt[i] != {WAIT_W{1'b1}}) begin
                    w_wait_cnt_nxt[i] = r_wait_cnt[i] + WAIT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_tx        <= 1'b0;
            r_busy      <= 1'b0;
            r_data      <= '0;
            r_grant_idx <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_wait_cnt[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_tx        <= w_tx_nxt;
            r_busy      <= w_busy_nxt;
            r_data      <= w_data_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            for (int i = 0; i < N_REQ; i++) begin
                r_wait_cnt[i] <= w_wait_cnt_nxt[i];
            end
        end
    end

    assign tx_o        = r_tx;
    assign busy_o      = r_busy;
    assign data_o      = r_data;
    assign grant_idx_o = r_grant_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            wait_cnt_o[i*WAIT_W +: WAIT_W] = r_wait_cnt[i];
        end
    end

endmodule

// File: tb/tb_br_local_inject_arbiter.sv
// Bench for br_local_inject_arbiter (3 requesters, 4-bit wait counters, 16-bit payload).
// Stimulus pushes the expected ack record before driving ack_i; a negedge monitor
// pops and compares whenever req_ack_o is non-zero.
`timescale 1ns/1ps
module tb_br_local_inject_arbiter;

    localparam int N  = 3;
    localparam int WW = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    localparam logic [DW-1:0] D0 = 16'hA0A0;
    localparam logic [DW-1:0] D1 = 16'hB1B1;
    localparam logic [DW-1:0] D2 = 16'hC2C2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      req_i = '0;
    logic [N*DW-1:0]   req_data_i = {D2, D1, D0};
    logic [N-1:0]      req_ack_o;
    logic              tx_o;
    logic [DW-1:0]     data_o;
    logic              ack_i = 1'b0;
    logic              busy_o;
    logic [IW-1:0]     grant_idx_o;
    logic [N*WW-1:0]   wait_cnt_o;

    br_local_inject_arbiter #(
        .N_REQ  (N),
        .WAIT_W (WW),
        .DATA_W (DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .req_data_i  (req_data_i),
        .req_ack_o   (req_ack_o),
        .tx_o        (tx_o),
        .data_o      (data_o),
        .ack_i       (ack_i),
        .busy_o      (busy_o),
        .grant_idx_o (grant_idx_o),
        .wait_cnt_o  (wait_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic [WW-1:0] wcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [WW-1:0] wc(input int i);
        return wait_cnt_o[i*WW +: WW];
    endfunction

    function automatic logic [DW-1:0] dval(input int i);
        case (i)
            0:       return D0;
            1:       return D1;
            default: return D2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic push(input logic [N-1:0] a, input logic [DW-1:0] d,
                        input logic [IW-1:0] i, input logic [WW-1:0] w);
        exp_t e;
        e.ack = a; e.data = d; e.idx = i; e.wcnt = w;
        exp_q.push_back(e);
    endtask

    // Drive point: just after the rising edge. Sample point: the falling edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic wait_tx(input string nm);
        int k = 0;
        smp();
        while (tx_o !== 1'b1 && k < 20) begin
            cyc();
            smp();
            k++;
        end
        chk({nm, " tx rise"}, 64'(tx_o), 64'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        if (req_ack_o !== '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected req_ack_o", 64'(req_ack_o), 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk("sb req_ack_o", 64'(req_ack_o), 64'(m_e.ack));
                chk("sb data_o",    64'(data_o),    64'(m_e.data));
                chk("sb grant_idx", 64'(grant_idx_o), 64'(m_e.idx));
                chk("sb tx_o",      64'(tx_o),      64'd1);
                chk("sb wait_cnt",  64'(wc(int'(m_e.idx))), 64'(m_e.wcnt));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ord  [4];
        int wexp [4];
        ord  = '{2, 0, 1, 2};
        wexp = '{1, 6, 11, 12};

        // Reset state
        repeat (2) cyc();
        smp();
        chk("rst tx_o",        64'(tx_o),        64'd0);
        chk("rst data_o",      64'(data_o),      64'd0);
        chk("rst req_ack_o",   64'(req_ack_o),   64'd0);
        chk("rst busy_o",      64'(busy_o),      64'd0);
        chk("rst grant_idx_o", 64'(grant_idx_o), 64'd0);
        chk("rst wait_cnt_o",  64'(wait_cnt_o),  64'd0);
        cyc();
        rst_ni = 1'b1;
        smp();
        chk("idle tx_o", 64'(tx_o), 64'd0);

        // Single requester 1: latency, ack routing, holdoff spacing, re-grant
        cyc(); req_i = 3'b010;                        // t0
        smp(); chk("t0 tx_o", 64'(tx_o), 64'd0);
        cyc(); smp();                                 // t0+1
        chk("t1 tx_o",      64'(tx_o),        64'd1);
        chk("t1 data_o",    64'(data_o),      64'(D1));
        chk("t1 grant_idx", 64'(grant_idx_o), 64'd1);
        chk("t1 busy_o",    64'(busy_o),      64'd1);
        cyc(); smp(); chk("t2 tx_o held", 64'(tx_o), 64'd1);
        cyc(); push(3'b010, D1, 2'd1, 4'd1); ack_i = 1'b1; smp();   // t0+3
        cyc(); ack_i = 1'b0; smp();                   // t0+4 holdoff
        chk("t4 tx_o",      64'(tx_o),   64'd0);
        chk("t4 busy_o",    64'(busy_o), 64'd0);
        chk("t4 wcnt1 clr", 64'(wc(1)),  64'd0);
        cyc(); smp(); chk("t5 tx_o idle", 64'(tx_o), 64'd0);
        cyc(); smp(); chk("t6 regrant",   64'(tx_o), 64'd1);
        cyc(); push(3'b010, D1, 2'd1, 4'd2); ack_i = 1'b1; smp();   // t0+7
        cyc(); ack_i = 1'b0; req_i = '0;              // t0+8 holdoff
        cyc(); ack_i = 1'b1;                          // t0+9 idle: stray ack
        smp();
        chk("idle ack req_ack_o", 64'(req_ack_o), 64'd0);
        chk("idle ack busy_o",    64'(busy_o),    64'd0);
        chk("idle ack tx_o",      64'(tx_o),      64'd0);
        cyc(); ack_i = 1'b0; req_i = 3'b111;

        // All three requesting; pointer left at 2 so order is 2,0,1,2
        for (int k = 0; k < 4; k++) begin
            wait_tx("rr");
            cyc();
            cyc(); push(3'(1 << ord[k]), dval(ord[k]), IW'(ord[k]), WW'(wexp[k])); ack_i = 1'b1;
            smp();
            cyc(); ack_i = 1'b0;
            if (k == 3) req_i = '0;
            smp();
            chk("rr wcnt clr after ack", 64'(wc(ord[k])), 64'd0);
        end
        cyc(); cyc(); smp();
        chk("kept wcnt0", 64'(wc(0)), 64'd10);
        chk("kept wcnt1", 64'(wc(1)), 64'd5);

        // Requester 2 drops req during grant
        cyc(); req_i = 3'b100;
        cyc(); req_i = '0; req_data_i[2*DW +: DW] = 16'hDEAD;
        smp();
        chk("drop tx_o",      64'(tx_o),        64'd1);
        chk("drop grant_idx", 64'(grant_idx_o), 64'd2);
        cyc(); smp();
        chk("drop tx held",   64'(tx_o),   64'd1);
        chk("drop data held", 64'(data_o), 64'(D2));
        cyc(); push(3'b100, D2, 2'd2, 4'd1); ack_i = 1'b1; smp();
        cyc(); ack_i = 1'b0; req_data_i[2*DW +: DW] = D2;

        // Move pointer to 1, then grant 2 and reset mid-grant
        cyc(); req_i = 3'b001;
        wait_tx("ptr setup");
        cyc(); push(3'b001, D0, 2'd0, 4'd11); ack_i = 1'b1; smp();
        cyc(); ack_i = 1'b0; req_i = '0;
        cyc(); req_i = 3'b101;
        wait_tx("pre-reset");
        chk("pre-reset grant_idx", 64'(grant_idx_o), 64'd2);
        cyc(); ack_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst tx_o",      64'(tx_o),        64'd0);
        chk("midrst data_o",    64'(data_o),      64'd0);
        chk("midrst busy_o",    64'(busy_o),      64'd0);
        chk("midrst grant_idx", 64'(grant_idx_o), 64'd0);
        chk("midrst req_ack_o", 64'(req_ack_o),   64'd0);
        chk("midrst wait_cnt",  64'(wait_cnt_o),  64'd0);
        smp();
        cyc(); ack_i = 1'b0;
        cyc(); rst_ni = 1'b1;
        smp(); chk("release tx_o", 64'(tx_o), 64'd0);
        cyc(); smp();
        chk("post-rst tx_o",      64'(tx_o),        64'd1);
        chk("post-rst grant_idx", 64'(grant_idx_o), 64'd0);
        chk("post-rst data_o",    64'(data_o),      64'(D0));
        cyc(); push(3'b001, D0, 2'd0, 4'd1); ack_i = 1'b1; smp();
        cyc(); ack_i = 1'b0; req_i = '0;

        // Saturation: req 0 waits while req 1 holds a long grant
        cyc(); req_i = 3'b011;
        wait_tx("sat");
        chk("sat grant_idx", 64'(grant_idx_o), 64'd1);
        repeat (20) cyc();
        smp();
        chk("sat wcnt0",  64'(wc(0)), 64'd15);
        chk("sat wcnt1",  64'(wc(1)), 64'd1);
        chk("sat tx held", 64'(tx_o), 64'd1);
        cyc(); push(3'b010, D1, 2'd1, 4'd1); ack_i = 1'b1; smp();
        cyc(); ack_i = 1'b0; req_i = 3'b001;
        smp();
        chk("sat no wrap wcnt0", 64'(wc(0)), 64'd15);
        chk("sat clr wcnt1",     64'(wc(1)), 64'd0);
        wait_tx("sat next");
        cyc(); push(3'b001, D0, 2'd0, 4'd15); ack_i = 1'b1; smp();
        cyc(); ack_i = 1'b0; req_i = '0;
        smp(); chk("sat clr wcnt0", 64'(wc(0)), 64'd0);

        repeat (3) cyc();
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
